spike_event_monitor: RTL and testbench
======================================

SPIKE_EVENT_MONITOR -- requirements
Module: spike_event_monitor

Interface
REQ-001 Parameter CNT_W, 8, width of spike_count, isi and all internal counters.
REQ-002 Parameter REFRACT_CYC, 4, refractory length in clocks after an accepted event (legal 1..15).
REQ-003 Parameter BURST_ISI, 16, an ISI strictly below this value flags a burst.
REQ-004 clock  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 spike  input  1  level spike output of the upstream LinearHodgkinHuxleyModel neuron (high while membrane >= threshold).
REQ-007 enable  input  1  monitor enable.
REQ-008 window_len  input  CNT_W  rate-window length in clocks; 0 means 2^CNT_W.
REQ-009 spike_event  output  1  one-clock pulse per accepted spike.
REQ-010 spike_count  output  CNT_W  accepted spikes in the last completed window.
REQ-011 count_valid  output  1  one-clock pulse when spike_count updates.
REQ-012 isi  output  CNT_W  last inter-spike interval in clocks, saturating.
REQ-013 isi_valid  output  1  level; high once at least two events have been accepted since reset.
REQ-014 burst  output  1  level; isi_valid AND isi < BURST_ISI.

Function
REQ-015 The block SHALL register spike into spike_q every clock, regardless of state; rise = spike & ~spike_q.
REQ-016 The FSM SHALL have states IDLE, ARMED and REFRACT.
REQ-017 IDLE->ARMED when enable=1; ARMED or REFRACT->IDLE when enable=0 (takes priority over all else).
REQ-018 In ARMED, a rise SHALL be accepted as an event: the FSM enters REFRACT and ref_cnt loads REFRACT_CYC.
REQ-019 In REFRACT, ref_cnt SHALL decrement each clock; on the clock where ref_cnt==1 the FSM returns to ARMED; rises seen in REFRACT are discarded, not queued.
REQ-020 A spike still high when ARMED is re-entered SHALL NOT produce an event (edge-only acceptance).
REQ-021 spike_event SHALL be registered: high for exactly the one clock following the edge at which the event is accepted.
REQ-022 The window counter SHALL latch window_len at window start and count 0..len-1; at terminal count it pulses count_valid, loads spike_count with the accumulator (plus any event accepted on that same clock), clears the accumulator and relatches window_len.
REQ-023 The accumulator SHALL saturate at 2^CNT_W-1.
REQ-024 The ISI counter SHALL increment each clock, saturating at 2^CNT_W-1; on an accepted event isi loads the pre-update counter value and the counter loads 1.
REQ-025 isi_valid SHALL set on the second accepted event after reset and stay set until reset.
REQ-026 When enable=0, window, accumulator and ISI counters SHALL hold; outputs hold their values; spike_event and count_valid stay low.
REQ-027 Changing window_len mid-window SHALL affect only the next window.

Reset
REQ-028 reset SHALL asynchronously force state=IDLE, spike_q=0, all counters=0, and spike_event, count_valid, spike_count, isi, isi_valid, burst all 0.
REQ-029 Reset asserted mid-window or in REFRACT SHALL discard the partial window and refractory; the first clock after deassertion behaves as from power-up.

Structure
REQ-030 A shared package/header SHALL hold the FSM state encoding, CNT_W default and the saturating-increment helper.
REQ-031 The window counter plus accumulator SHALL be one sub-module, spike_rate_window; the FSM, edge detection and ISI logic stay at top level.

Verification
REQ-032 Reset, enable=1, one spike pulse 3 clocks wide -> exactly one spike_event, one clock after the rise; no second event.
REQ-033 REFRACT_CYC=4, rises 2 clocks apart -> second rise ignored; rises 6 clocks apart -> both accepted, isi=6, isi_valid=1, burst=1.
REQ-034 window_len=10, 3 events in window, a 4th on the terminal clock -> count_valid pulse with spike_count=4, next window starts at 0.
REQ-035 No events for 300 clocks, then 2 events -> isi=255 (saturated), burst=0.
REQ-036 enable dropped for 20 clocks with spike toggling -> no events, counters frozen; re-enable resumes window where it stopped.
REQ-037 reset pulsed in REFRACT mid-window -> all outputs 0 immediately (asynchronously); the next rise after release is accepted normally with isi_valid=0.

Source files
------------

// File: rtl/spike_event_monitor_pkg.sv
// Shared definitions for the spike event monitor: FSM state encoding,
// default counter width and the saturating-increment helper.
package spike_event_monitor_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_REFRACT = 2'd2
  } state_t;

  // Increment that sticks at max_val instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max_val);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/spike_rate_window.sv
// Rate window: counts accepted events over a programmable window of clocks
// and publishes the total once per window with a one-clock valid pulse.
module spike_rate_window
  import spike_event_monitor_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             event_in,
  input  logic [CNT_W-1:0] window_len,
  output logic [CNT_W-1:0] spike_count,
  output logic             count_valid
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] len_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] acc_reg;
  logic [CNT_W-1:0] count_reg;
  logic             count_valid_reg;

  logic [CNT_W-1:0] eff_len;
  logic [CNT_W-1:0] acc_next;
  logic             terminal;

  // The window length is sampled on the first clock of each window, so a
  // change mid-window only shapes the next one. Length 0 wraps to 2^CNT_W
  // naturally because 0 - 1 is the all-ones terminal count.
  always_comb begin
    eff_len  = (cnt_reg == '0) ? window_len : len_reg;
    terminal = (cnt_reg == eff_len - ONE);
    acc_next = event_in ? CNT_W'(sat_inc(32'(acc_reg), 32'(CNT_MAX))) : acc_reg;
  end

  // Window counter, accumulator and published count; everything holds while not running.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      len_reg         <= '0;
      cnt_reg         <= '0;
      acc_reg         <= '0;
      count_reg       <= '0;
      count_valid_reg <= 1'b0;
    end else begin
      count_valid_reg <= 1'b0;
      if (run) begin
        if (cnt_reg == '0) begin
          len_reg <= window_len;
        end
        if (terminal) begin
          cnt_reg         <= '0;
          count_reg       <= acc_next;
          count_valid_reg <= 1'b1;
          acc_reg         <= '0;
        end else begin
          cnt_reg <= cnt_reg + ONE;
          acc_reg <= acc_next;
        end
      end
    end
  end

  assign spike_count = count_reg;
  assign count_valid = count_valid_reg;

endmodule

// File: rtl/spike_event_monitor.sv
// Spike event monitor: turns the level spike output of a neuron model into
// debounced single-clock events with a refractory period, and reports the
// spike rate per window, the inter-spike interval and a burst flag.
module spike_event_monitor
  import spike_event_monitor_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int REFRACT_CYC = 4,
  parameter int BURST_ISI   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             spike,
  input  logic             enable,
  input  logic [CNT_W-1:0] window_len,
  output logic             spike_event,
  output logic [CNT_W-1:0] spike_count,
  output logic             count_valid,
  output logic [CNT_W-1:0] isi,
  output logic             isi_valid,
  output logic             burst
);

  localparam logic [3:0]       REF_LOAD  = 4'(REFRACT_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W:0]   BURST_LIM = (CNT_W+1)'(BURST_ISI);

  state_t           state_reg, state_next;
  logic [3:0]       ref_reg, ref_next;
  logic             spike_q_reg;
  logic             spike_event_reg;
  logic [CNT_W-1:0] isi_cnt_reg;
  logic [CNT_W-1:0] isi_reg;
  logic             seen_reg;
  logic             isi_valid_reg;
  logic             rise;
  logic             accept;

  assign rise = spike & ~spike_q_reg;

  // Next-state logic: disable wins over everything; only ARMED accepts a rise.
  always_comb begin
    state_next = state_reg;
    ref_next   = ref_reg;
    accept     = 1'b0;
    if (!enable) begin
      state_next = ST_IDLE;
      ref_next   = 4'd0;
    end else begin
      case (state_reg)
        ST_IDLE: state_next = ST_ARMED;
        ST_ARMED: begin
          if (rise) begin
            accept     = 1'b1;
            state_next = ST_REFRACT;
            ref_next   = REF_LOAD;
          end
        end
        ST_REFRACT: begin
          ref_next = ref_reg - 4'd1;
          if (ref_reg == 4'd1) begin
            state_next = ST_ARMED;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // State register, spike history and the registered event pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      ref_reg         <= 4'd0;
      spike_q_reg     <= 1'b0;
      spike_event_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      ref_reg         <= ref_next;
      spike_q_reg     <= spike;
      spike_event_reg <= accept;
    end
  end

  // Inter-spike interval: free-running saturating counter captured on each event.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      isi_cnt_reg   <= '0;
      isi_reg       <= '0;
      seen_reg      <= 1'b0;
      isi_valid_reg <= 1'b0;
    end else if (enable) begin
      if (accept) begin
        isi_reg     <= isi_cnt_reg;
        isi_cnt_reg <= CNT_W'(1);
        seen_reg    <= 1'b1;
        if (seen_reg) begin
          isi_valid_reg <= 1'b1;
        end
      end else begin
        isi_cnt_reg <= CNT_W'(sat_inc(32'(isi_cnt_reg), 32'(CNT_MAX)));
      end
    end
  end

  spike_rate_window #(
    .CNT_W(CNT_W)
  ) u_window (
    .clock      (clock),
    .reset      (reset),
    .run        (enable),
    .event_in   (accept),
    .window_len (window_len),
    .spike_count(spike_count),
    .count_valid(count_valid)
  );

  assign spike_event = spike_event_reg;
  assign isi         = isi_reg;
  assign isi_valid   = isi_valid_reg;
  assign burst       = isi_valid_reg && ({1'b0, isi_reg} < BURST_LIM);

endmodule

// File: tb/tb_spike_event_monitor.sv
// Bench for spike_event_monitor: a cycle table for edge/refractory/ISI
// behaviour, then hand sequences for windows, enable gaps, saturation and
// asynchronous reset. A second instance with a 1-clock refractory period
// allows four events inside a 10-clock window.
module tb_spike_event_monitor;

  localparam int CNT_W = 8;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic             clock = 1'b0;
  logic             reset;
  logic             spike;
  logic             enable;
  logic [CNT_W-1:0] window_len;

  logic             d_event, d_cv, d_iv, d_burst;
  logic [CNT_W-1:0] d_count, d_isi;
  logic             f_event, f_cv, f_iv, f_burst;
  logic [CNT_W-1:0] f_count, f_isi;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  spike_event_monitor #(.CNT_W(CNT_W), .REFRACT_CYC(4), .BURST_ISI(16)) u_dut (
    .clock(clock), .reset(reset), .spike(spike), .enable(enable),
    .window_len(window_len), .spike_event(d_event), .spike_count(d_count),
    .count_valid(d_cv), .isi(d_isi), .isi_valid(d_iv), .burst(d_burst)
  );

  spike_event_monitor #(.CNT_W(CNT_W), .REFRACT_CYC(1), .BURST_ISI(16)) u_fast (
    .clock(clock), .reset(reset), .spike(spike), .enable(enable),
    .window_len(window_len), .spike_event(f_event), .spike_count(f_count),
    .count_valid(f_cv), .isi(f_isi), .isi_valid(f_iv), .burst(f_burst)
  );

  typedef struct {
    logic       en;
    logic       sp;
    logic       ev;
    logic [7:0] isi;
    logic       iv;
    logic       bu;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(input logic en, input logic sp, input logic ev,
                              input logic [7:0] isi_v, input logic iv, input logic bu);
    vec_t v;
    v.en = en; v.sp = sp; v.ev = ev; v.isi = isi_v; v.iv = iv; v.bu = bu;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic step(input logic en, input logic sp);
    enable = en;
    spike  = sp;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    spike = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // 3-wide pulse, 6-apart rises, rise inside refractory, spike held across re-arm
    vecs[0]  = mk(H, L, L, 8'd0, L, L);
    vecs[1]  = mk(H, H, H, 8'd1, L, L);
    vecs[2]  = mk(H, H, L, 8'd1, L, L);
    vecs[3]  = mk(H, H, L, 8'd1, L, L);
    vecs[4]  = mk(H, L, L, 8'd1, L, L);
    vecs[5]  = mk(H, L, L, 8'd1, L, L);
    vecs[6]  = mk(H, L, L, 8'd1, L, L);
    vecs[7]  = mk(H, H, H, 8'd6, H, H);
    vecs[8]  = mk(H, L, L, 8'd6, H, H);
    vecs[9]  = mk(H, H, L, 8'd6, H, H);
    vecs[10] = mk(H, L, L, 8'd6, H, H);
    vecs[11] = mk(H, L, L, 8'd6, H, H);
    vecs[12] = mk(H, L, L, 8'd6, H, H);
    vecs[13] = mk(H, L, L, 8'd6, H, H);
    vecs[14] = mk(H, H, H, 8'd7, H, H);
    for (int i = 15; i < 21; i++) vecs[i] = mk(H, H, L, 8'd7, H, H);
    vecs[21] = mk(H, L, L, 8'd7, H, H);

    window_len = 8'd10;

    // reset state
    reset = 1'b1; enable = 1'b0; spike = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst.event", d_event, 0);
    check("rst.count", d_count, 0);
    check("rst.cv", d_cv, 0);
    check("rst.isi", d_isi, 0);
    check("rst.iv", d_iv, 0);
    check("rst.burst", d_burst, 0);
    reset = 1'b0;

    // table-driven edge / refractory / ISI vectors
    for (int i = 0; i < 22; i++) begin
      step(vecs[i].en, vecs[i].sp);
      check($sformatf("v%0d.event", i), d_event, vecs[i].ev);
      check($sformatf("v%0d.isi", i), d_isi, vecs[i].isi);
      check($sformatf("v%0d.iv", i), d_iv, vecs[i].iv);
      check($sformatf("v%0d.burst", i), d_burst, vecs[i].bu);
      $display("vec %0d en=%0d sp=%0d -> event=%0d isi=%0d iv=%0d burst=%0d",
               i, vecs[i].en, vecs[i].sp, d_event, d_isi, d_iv, d_burst);
    end

    // windows: 4 events with the last on the terminal clock, then an empty
    // window, with window_len changed mid-window affecting only the next one
    do_reset();
    window_len = 8'd10;
    for (int k = 0; k < 25; k++) begin
      logic sp;
      logic exp_cv;
      logic [7:0] exp_cnt;
      sp = (k == 3 || k == 5 || k == 7 || k == 9);
      if (k >= 12) window_len = 8'd5;
      exp_cv  = (k == 9 || k == 19 || k == 24);
      exp_cnt = (k < 9) ? 8'd0 : ((k < 19) ? 8'd4 : 8'd0);
      step(1'b1, sp);
      check($sformatf("win.k%0d.cv", k), f_cv, exp_cv);
      check($sformatf("win.k%0d.count", k), f_count, exp_cnt);
      $display("win k=%0d sp=%0d -> cv=%0d count=%0d", k, sp, f_cv, f_count);
    end

    // event with ISI exactly at the burst threshold
    step(1'b1, 1'b1);
    check("thr.event", f_event, 1);
    check("thr.isi", f_isi, 16);
    check("thr.burst", f_burst, 0);
    step(1'b1, 1'b0);

    // enable dropped 20 clocks with spike toggling
    for (int i = 0; i < 20; i++) begin
      step(1'b0, (i % 2) == 0);
      check($sformatf("dis%0d.fevent", i), f_event, 0);
      check($sformatf("dis%0d.devent", i), d_event, 0);
      check($sformatf("dis%0d.cv", i), f_cv, 0);
      check($sformatf("dis%0d.isi", i), f_isi, 16);
    end
    $display("disabled 20 clocks: isi=%0d count=%0d", f_isi, f_count);

    // resume: window continues from count 2 of a 5-clock window
    for (int r = 1; r <= 3; r++) begin
      step(1'b1, 1'b0);
      check($sformatf("res%0d.cv", r), f_cv, (r == 3));
    end
    check("res.count", f_count, 1);
    step(1'b1, 1'b1);
    check("res.event", f_event, 1);
    check("res.isi", f_isi, 5);
    check("res.burst", f_burst, 1);
    $display("resume: count=%0d isi=%0d burst=%0d", f_count, f_isi, f_burst);

    // long idle saturates the ISI counter
    repeat (300) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("sat.event", d_event, 1);
    check("sat.isi", d_isi, 255);
    check("sat.iv", d_iv, 1);
    check("sat.burst", d_burst, 0);
    repeat (5) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("sat2.event", d_event, 1);
    check("sat2.isi", d_isi, 6);
    check("sat2.burst", d_burst, 1);
    $display("saturation: isi=%0d burst=%0d", d_isi, d_burst);

    // asynchronous reset while in refractory, mid-window
    step(1'b1, 1'b1);
    reset = 1'b1;
    #1;
    check("arst.event", d_event, 0);
    check("arst.count", d_count, 0);
    check("arst.cv", d_cv, 0);
    check("arst.isi", d_isi, 0);
    check("arst.iv", d_iv, 0);
    check("arst.burst", d_burst, 0);
    check("arst.fcount", f_count, 0);
    #2;
    reset = 1'b0;
    spike = 1'b0;
    step(1'b1, 1'b0);
    check("post.event0", d_event, 0);
    step(1'b1, 1'b1);
    check("post.event", d_event, 1);
    check("post.isi", d_isi, 1);
    check("post.iv", d_iv, 0);
    check("post.burst", d_burst, 0);
    $display("post-reset: event=%0d isi=%0d iv=%0d", d_event, d_isi, d_iv);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
